// File: rtl/cpu_types_pkg.sv
// Shared CPU types: datapath word, fetch FSM state encoding and default reset PC.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    KILL   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_INIT_DEFAULT = 32'h0;

endpackage

// File: rtl/fetch_stage_if.sv
// Port bundle for the fetch stage: fs is the stage's view, tb the driver's view.
interface fetch_stage_if;
  import cpu_types_pkg::*;

  logic  ihit;
  word_t iload;
  logic  iREN;
  word_t imemaddr;
  logic  stall;
  logic  redirect_en;
  word_t redirect_addr;
  logic  halt;
  word_t instr;
  word_t pc_plus_4;
  logic  valid;
  word_t fetch_count;
  word_t miss_cycles;

  modport fs (
    input  ihit, iload, stall, redirect_en, redirect_addr, halt,
    output iREN, imemaddr, instr, pc_plus_4, valid, fetch_count, miss_cycles
  );

  modport tb (
    output ihit, iload, stall, redirect_en, redirect_addr, halt,
    input  iREN, imemaddr, instr, pc_plus_4, valid, fetch_count, miss_cycles
  );

endinterface

// File: rtl/fetch_perf_ctr.sv
// Fetch performance counters: delivered instructions and icache miss cycles.
// Both counters wrap silently; freezing in HALTED falls out of the increment
// qualifiers, which are both low while halted.
module fetch_perf_ctr (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        fetch_inc,
  input  logic        miss_inc,
  output logic [31:0] fetch_count,
  output logic [31:0] miss_cycles
);

  // Count qualified events; cleared only by reset
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_count <= '0;
      miss_cycles <= '0;
    end else begin
      if (fetch_inc) fetch_count <= fetch_count + 32'd1;
      if (miss_inc)  miss_cycles <= miss_cycles + 32'd1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the icache request and feeds
// the fetch latch. Optional perf counters are built when FETCH_PERF_EN is defined.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | normal fetch; PC advances on each unstalled hit
// KILL   | wrong-path miss outstanding; jump to target once it returns
// HALTED | halt committed; no requests, PC frozen until reset
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter int              WORD_W  = 32,
  parameter logic [WORD_W-1:0] PC_INIT = PC_INIT_DEFAULT
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] iload,
  output logic              iREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [WORD_W-1:0] redirect_addr,
  input  logic              halt,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] pc_plus_4,
  output logic              valid,
  output logic [31:0]       fetch_count,
  output logic [31:0]       miss_cycles
);

  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] target;
  fetch_state_t      state;

  // Request and fetch-latch outputs are combinational off pc/state so a hit
  // is delivered in the same cycle it arrives
  always_comb begin
    imemaddr  = pc;
    iREN      = (state != HALTED);
    instr     = iload;
    pc_plus_4 = pc + WORD_W'(4);
    valid     = (state == RUN) && ihit && !redirect_en && !halt;
  end

  // PC / state / redirect target; pc only moves on a hit so the cache sees a
  // stable address for the whole miss
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc     <= PC_INIT;
      state  <= RUN;
      target <= '0;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state <= HALTED;
          end else if (redirect_en) begin
            if (ihit) begin
              pc <= redirect_addr;
            end else begin
              target <= redirect_addr;
              state  <= KILL;
            end
          end else if (ihit && !stall) begin
            pc <= pc + WORD_W'(4);
          end
        end
        KILL: begin
          if (halt) begin
            state <= HALTED;
          end else begin
            if (redirect_en) target <= redirect_addr;
            if (ihit) begin
              pc    <= redirect_en ? redirect_addr : target;
              state <= RUN;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= RUN;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_ctr u_perf (
    .CLK         (CLK),
    .nRST        (nRST),
    .fetch_inc   (valid && !stall),
    .miss_inc    (iREN && !ihit),
    .fetch_count (fetch_count),
    .miss_cycles (miss_cycles)
  );
`else
  assign fetch_count = '0;
  assign miss_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, miss, stall, redirect
// during miss, same-cycle redirect, halt, reset mid-KILL and PC wrap.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] imemaddr;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_addr;
  logic        halt;
  logic [31:0] instr;
  logic [31:0] pc_plus_4;
  logic        valid;
  logic [31:0] fetch_count;
  logic [31:0] miss_cycles;

  int n_cmp = 0;
  int n_err = 0;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  fetch_stage dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .ihit          (ihit),
    .iload         (iload),
    .iREN          (iREN),
    .imemaddr      (imemaddr),
    .stall         (stall),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .instr         (instr),
    .pc_plus_4     (pc_plus_4),
    .valid         (valid),
    .fetch_count   (fetch_count),
    .miss_cycles   (miss_cycles)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic perf_chk(input string tag, input logic [31:0] fc, input logic [31:0] mc);
    chk({tag, "_fetch_count"}, fetch_count, PERF ? fc : 32'h0);
    chk({tag, "_miss_cycles"}, miss_cycles, PERF ? mc : 32'h0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; iload = 32'h0; stall = 1'b0;
    redirect_en = 1'b0; redirect_addr = 32'h0; halt = 1'b0;
    #2;
    chk("rst_imemaddr", imemaddr, 32'h0);
    chk("rst_pc_plus_4", pc_plus_4, 32'h4);
    chk("rst_iREN", iREN, 1);
    chk("rst_valid_nohit", valid, 0);
    perf_chk("rst", 0, 0);
    ihit = 1'b1; #1;
    chk("rst_valid_hit", valid, 1);
    ihit = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    // sequential fetch 0,4,8,C
    ihit = 1'b1; iload = 32'hA0A0_0001; #1;
    chk("seq0_instr", instr, 32'hA0A0_0001);
    chk("seq0_addr", imemaddr, 32'h0);
    chk("seq0_valid", valid, 1);
    chk("seq0_p4", pc_plus_4, 32'h4);
    tick();
    chk("seq1_addr", imemaddr, 32'h4);
    chk("seq1_p4", pc_plus_4, 32'h8);
    chk("seq1_valid", valid, 1);
    tick();
    chk("seq2_addr", imemaddr, 32'h8);
    chk("seq2_p4", pc_plus_4, 32'hC);
    tick();
    chk("seq3_addr", imemaddr, 32'hC);
    chk("seq3_p4", pc_plus_4, 32'h10);
    tick();

    // three-cycle miss at 0x10
    ihit = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      chk("miss_addr", imemaddr, 32'h10);
      chk("miss_valid", valid, 0);
      tick();
    end
    ihit = 1'b1; #1;
    chk("miss_end_addr", imemaddr, 32'h10);
    chk("miss_end_valid", valid, 1);
    perf_chk("miss", 4, 3);
    tick();

    // stall for two cycles at 0x14
    stall = 1'b1; #1;
    for (int i = 0; i < 2; i++) begin
      chk("stall_addr", imemaddr, 32'h14);
      chk("stall_valid", valid, 1);
      tick();
    end
    stall = 1'b0; #1;
    chk("stall_drop_addr", imemaddr, 32'h14);
    tick();
    chk("post_stall_addr", imemaddr, 32'h18);
    perf_chk("post_stall", 6, 3);

    // redirect during a miss: 0x100 then 0x200, hit arrives later
    ihit = 1'b0; #1;
    chk("rm0_valid", valid, 0);
    tick();
    redirect_en = 1'b1; redirect_addr = 32'h100; #1;
    chk("rm1_addr", imemaddr, 32'h18);
    chk("rm1_valid", valid, 0);
    tick();
    redirect_addr = 32'h200; #1;
    chk("rm2_addr", imemaddr, 32'h18);
    chk("rm2_valid", valid, 0);
    tick();
    redirect_en = 1'b0; #1;
    chk("rm3_addr", imemaddr, 32'h18);
    tick();
    ihit = 1'b1; #1;
    chk("rm4_addr", imemaddr, 32'h18);
    chk("rm4_valid_killed", valid, 0);
    chk("rm4_iREN", iREN, 1);
    tick();
    chk("rm_target_addr", imemaddr, 32'h200);
    chk("rm_target_valid", valid, 1);
    perf_chk("rm", 6, 7);

    // same-cycle redirect and hit
    redirect_en = 1'b1; redirect_addr = 32'h80; #1;
    chk("rh_valid", valid, 0);
    tick();
    redirect_en = 1'b0; #1;
    chk("rh_addr", imemaddr, 32'h80);
    chk("rh_next_valid", valid, 1);

    // halt beats redirect
    halt = 1'b1; redirect_en = 1'b1; redirect_addr = 32'h300; #1;
    chk("halt_valid", valid, 0);
    chk("halt_iREN_before", iREN, 1);
    tick();
    halt = 1'b0; redirect_en = 1'b0; #1;
    chk("halted_iREN", iREN, 0);
    chk("halted_valid", valid, 0);
    chk("halted_addr", imemaddr, 32'h80);
    tick(); tick();
    chk("halted_iREN_stays", iREN, 0);
    chk("halted_addr_stays", imemaddr, 32'h80);
    perf_chk("halted", 6, 7);

    // reset leaves HALTED
    nRST = 1'b0; #1;
    chk("rst2_addr", imemaddr, 32'h0);
    chk("rst2_iREN", iREN, 1);
    nRST = 1'b1; #1;
    chk("rst2_valid", valid, 1);

    // reset mid-KILL
    ihit = 1'b0; redirect_en = 1'b1; redirect_addr = 32'h400; #1;
    tick();
    redirect_en = 1'b0; #1;
    chk("kill_addr", imemaddr, 32'h0);
    chk("kill_valid", valid, 0);
    nRST = 1'b0; #1;
    chk("rst3_addr", imemaddr, 32'h0);
    chk("rst3_iREN", iREN, 1);
    perf_chk("rst3", 0, 0);
    nRST = 1'b1; ihit = 1'b1; #1;
    chk("rst3_valid_run", valid, 1);
    tick();
    chk("rst3_next_addr", imemaddr, 32'h4);

    // PC wrap at top of address space
    redirect_en = 1'b1; redirect_addr = 32'hFFFF_FFFC; #1;
    tick();
    redirect_en = 1'b0; #1;
    chk("wrap_addr", imemaddr, 32'hFFFF_FFFC);
    chk("wrap_p4", pc_plus_4, 32'h0);
    tick();
    chk("wrap_next_addr", imemaddr, 32'h0);
    perf_chk("wrap", 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline. Owns the PC and drives the icache request. Presents instruction, PC+4 and a valid qualifier to the fetch latch, which feeds decode. Handles stalls from the hazard unit, branch/jump redirects from later stages, and halt.

Parameters:
PC_INIT, 32'h0000_0000, PC value loaded on reset.
WORD_W, 32, datapath width; matches word_t.

Ports:
CLK  in  1  system clock, rising edge.
nRST  in  1  asynchronous active-low reset.
ihit  in  1  icache: iload valid for current imemaddr this cycle.
iload  in  WORD_W  icache instruction data.
iREN  out  1  icache read enable.
imemaddr  out  WORD_W  icache address (= pc).
stall  in  1  hazard unit: fetch latch holding; do not advance PC.
redirect_en  in  1  taken branch / jump / JAL / JR resolved downstream.
redirect_addr  in  WORD_W  redirect target.
halt  in  1  halt instruction has committed.
instr  out  WORD_W  fetched instruction to fetch latch.
pc_plus_4  out  WORD_W  pc+4 to fetch latch.
valid  out  1  instr/pc_plus_4 are a real instruction; fetch latch inserts a bubble when 0.
fetch_count  out  32  perf counter (see Optional Feature).
miss_cycles  out  32  perf counter (see Optional Feature).

Behaviour:
- Registers: pc, state, target. state is one of RUN, KILL, HALTED.
- Reset (async, nRST=0): pc=PC_INIT, state=RUN, target=0, counters=0. Reset is honoured in any state, including mid-miss.
- Combinational outputs:
  - imemaddr=pc.
  - iREN=(state!=HALTED).
  - instr=iload.
  - pc_plus_4=pc+4, mod 2^32; wraps at 32'hFFFF_FFFC.
  - valid=(state==RUN && ihit && !redirect_en && !halt).
  - During reset, the outputs reflect pc=PC_INIT; valid=0 unless ihit.
- Cache contract: imemaddr is held stable while iREN=1 and ihit=0. The PC never changes during an outstanding miss.
- RUN:
  - halt=1: ->HALTED; pc unchanged. Halt beats redirect and stall.
  - redirect_en && ihit: pc<=redirect_addr; stay RUN; valid=0 (wrong-path kill).
  - redirect_en && !ihit: target<=redirect_addr; ->KILL.
  - ihit && !stall: pc<=pc+4.
  - ihit && stall: pc holds; the same address is refetched next cycle.
  - !ihit: pc holds (miss in progress).
  - Redirect overrides stall: a flush always proceeds.
- KILL (wrong-path miss still outstanding):
  - iREN=1, imemaddr=old pc, valid=0.
  - A new redirect_en overwrites target (youngest wins).
  - On ihit: pc<=target (or redirect_addr if redirect_en is asserted that cycle); ->RUN.
  - halt=1: ->HALTED.
- HALTED: iREN=0, valid=0, pc frozen. Exit only via nRST.
- Latency: one ihit cycle yields one valid instruction. Redirect-to-first-target-request is 1 cycle in RUN, or (remaining miss + 1) cycles from KILL.

Optional Feature:
FETCH_PERF_EN.
- Defined: fetch_count increments on every valid && !stall cycle. miss_cycles increments on every iREN && !ihit cycle. Both 32-bit, wrap silently, freeze in HALTED, clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package cpu_types_pkg gains: typedef enum logic [1:0] fetch_state_t {RUN, KILL, HALTED}; localparam word_t PC_INIT_DEFAULT=32'h0.
- word_t is reused from cpu_types_pkg.
- Port bundle fetch_stage_if with modports fs and tb.
- One natural sub-module: fetch_perf_ctr, instantiated only under FETCH_PERF_EN.

Test Plan:
- Reset then ihit=1 every cycle, no stall: imemaddr sequence 0,4,8,C; valid=1 each cycle; pc_plus_4 is 4,8,C,10.
- pc=8, ihit=0 for 3 cycles then 1: imemaddr=8 stable throughout; valid=0 then 1; miss_cycles=3 with FETCH_PERF_EN.
- pc=10, stall=1, ihit=1 for 2 cycles: pc stays 10, valid=1 both cycles; stall drops -> pc=14.
- pc=20 miss, redirect_en=1 with addr 0x100 at cycle 1, then 0x200 at cycle 2, ihit at cycle 4: imemaddr=20 through cycle 4; valid=0; next imemaddr=0x200.
- redirect_en and ihit in the same cycle at pc=30, target 0x80: valid=0; next imemaddr=0x80.
- halt=1 with redirect_en=1: iREN=0 next cycle and stays 0. nRST pulse mid-KILL: pc=PC_INIT, state RUN, iREN=1.
